// File: rtl/player_ctrl_if.sv
// player_ctrl_if
//  Bundles the keyboard/pause inputs and the motion outputs exchanged between
//  the player motion controller and its neighbours.
//  Signals:
//   key_down      10  key levels from the keyboard decoder, 1 = held
//   freeze         1  1 = hold all motion (pause/menu)
//   player_state   4  6 static, 7 right, 8 left, 9 up
//   player_jump    2  0 none, 1 rising, 2 falling
//   jump_busy      1  1 while player_jump != 0
//  Modports:
//   master  drives the keys and freeze, observes the motion outputs
//   slave   the controller itself
interface player_ctrl_if;
  logic [9:0] key_down;
  logic       freeze;
  logic [3:0] player_state;
  logic [1:0] player_jump;
  logic       jump_busy;

  modport master (
    output key_down, freeze,
    input  player_state, player_jump, jump_busy
  );

  modport slave (
    input  key_down, freeze,
    output player_state, player_jump, jump_busy
  );
endinterface

// File: rtl/player_ctrl.sv
// player_ctrl
//  Player motion controller sitting directly upstream of the sprite renderer.
//  Turns keyboard key levels into a registered player_state code and a jump
//  phase, timing each jump so the renderer climbs JUMP_HEIGHT vertical steps
//  (each STEP_CYCLES+1 clocks long) and then descends the same number.
//  Ports:
//   clk   system clock
//   rst   asynchronous active-low reset (0 = reset)
//   bus   player_ctrl_if.slave: key_down/freeze in,
//         player_state/player_jump/jump_busy out (all registered)
module player_ctrl #(
  parameter logic [3:0] KEY_LEFT    = 4'd0,
  parameter logic [3:0] KEY_RIGHT   = 4'd1,
  parameter logic [3:0] KEY_JUMP    = 4'd2,
  parameter int unsigned STEP_CYCLES = 2500000,
  parameter int unsigned JUMP_HEIGHT = 40
) (
  input  logic          clk,
  input  logic          rst,
  player_ctrl_if.slave  bus
);

  localparam logic [3:0]  ST_STATIC = 4'd6;
  localparam logic [3:0]  ST_RIGHT  = 4'd7;
  localparam logic [3:0]  ST_LEFT   = 4'd8;
  localparam logic [3:0]  ST_UP     = 4'd9;

  localparam logic [24:0] STEP_LAST   = 25'(STEP_CYCLES);
  localparam logic [6:0]  HEIGHT_LAST = 7'(JUMP_HEIGHT - 1);

  typedef enum logic [1:0] {
    J_IDLE = 2'd0,
    J_RISE = 2'd1,
    J_FALL = 2'd2
  } jump_state_e;

  jump_state_e j_state;
  logic [24:0] step_cnt;
  logic [6:0]  height_cnt;
  logic        key_jump_q;

  logic key_left;
  logic key_right;
  logic key_jump;
  logic jump_start;
  logic step_done;
  logic phase_done;

  // NOTE: every signal assigned in this always_comb gets a value on every
  // path, so no latch can be inferred.
  always_comb begin
    key_left   = bus.key_down[KEY_LEFT];
    key_right  = bus.key_down[KEY_RIGHT];
    key_jump   = bus.key_down[KEY_JUMP];
    // Rising edge of the jump key, only honoured on the ground and unfrozen;
    // an edge arriving during freeze is simply lost.
    jump_start = key_jump && !key_jump_q && (j_state == J_IDLE) && !bus.freeze;
    step_done  = (step_cnt == STEP_LAST);
    phase_done = step_done && (height_cnt == HEIGHT_LAST);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      j_state          <= J_IDLE;
      step_cnt         <= '0;
      height_cnt       <= '0;
      key_jump_q       <= 1'b0;
      bus.player_state <= ST_STATIC;
      bus.player_jump  <= 2'd0;
      bus.jump_busy    <= 1'b0;
    end else begin
      // Edge detector samples every clock, frozen or not, so a key held
      // across a freeze never produces a late start.
      key_jump_q <= key_jump;

      // Horizontal motion wins over "up"; left+right together cancel.
      if (bus.freeze)
        bus.player_state <= ST_STATIC;
      else if (key_left && !key_right)
        bus.player_state <= ST_LEFT;
      else if (key_right && !key_left)
        bus.player_state <= ST_RIGHT;
      else if ((j_state != J_IDLE) || jump_start)
        bus.player_state <= ST_UP;
      else
        bus.player_state <= ST_STATIC;

      if (!bus.freeze) begin
        unique case (j_state)
          J_IDLE: begin
            if (jump_start) begin
              j_state         <= J_RISE;
              step_cnt        <= '0;
              height_cnt      <= '0;
              bus.player_jump <= 2'd1;
              bus.jump_busy   <= 1'b1;
            end
          end
          J_RISE, J_FALL: begin
            if (phase_done) begin
              step_cnt   <= '0;
              height_cnt <= '0;
              if (j_state == J_RISE) begin
                j_state         <= J_FALL;
                bus.player_jump <= 2'd2;
              end else begin
                j_state         <= J_IDLE;
                bus.player_jump <= 2'd0;
                bus.jump_busy   <= 1'b0;
              end
            end else if (step_done) begin
              // Same cadence as the renderer: one vertical step per
              // STEP_CYCLES+1 clocks.
              step_cnt   <= '0;
              height_cnt <= height_cnt + 7'd1;
            end else begin
              step_cnt <= step_cnt + 25'd1;
            end
          end
          default: begin
            j_state         <= J_IDLE;
            bus.player_jump <= 2'd0;
            bus.jump_busy   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_player_ctrl.sv
// tb_player_ctrl
//  Self-checking bench for player_ctrl with STEP_CYCLES=4, JUMP_HEIGHT=3
//  (15 clocks per jump phase). A behavioural model tracks the jump as
//  "phase + clocks spent in phase" and recomputes the state code from the
//  key rules; directed scenarios are followed by a randomized run.
module tb_player_ctrl;

  localparam int STEP_CYCLES = 4;
  localparam int JUMP_HEIGHT = 3;
  localparam int PHASE_LEN   = JUMP_HEIGHT * (STEP_CYCLES + 1);
  localparam int KL = 0;
  localparam int KR = 1;
  localparam int KJ = 2;

  logic clk;
  logic rst;

  player_ctrl_if bus ();

  player_ctrl #(
    .KEY_LEFT    (4'd0),
    .KEY_RIGHT   (4'd1),
    .KEY_JUMP    (4'd2),
    .STEP_CYCLES (STEP_CYCLES),
    .JUMP_HEIGHT (JUMP_HEIGHT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int m_phase;     // 0 ground, 1 rising, 2 falling
  int m_elapsed;   // unfrozen clocks spent in the current phase
  bit m_kq;
  int m_state;
  int air_cnt;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_phase   = 0;
    m_elapsed = 0;
    m_kq      = 1'b0;
    m_state   = 6;
  endtask

  task automatic model_edge(input logic [9:0] k, input logic f);
    bit start;
    bit l, r;
    l     = k[KL];
    r     = k[KR];
    start = k[KJ] && !m_kq && (m_phase == 0) && !f;
    if (f)                   m_state = 6;
    else if (l != r)         m_state = l ? 8 : 7;
    else if (m_phase != 0 || start) m_state = 9;
    else                     m_state = 6;
    if (!f) begin
      if (start) begin
        m_phase   = 1;
        m_elapsed = 0;
      end else if (m_phase != 0) begin
        m_elapsed++;
        if (m_elapsed == PHASE_LEN) begin
          m_elapsed = 0;
          m_phase   = (m_phase == 1) ? 2 : 0;
        end
      end
    end
    m_kq = k[KJ];
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".state"}, int'(bus.player_state), m_state);
    check({tag, ".jump"},  int'(bus.player_jump),  m_phase);
    check({tag, ".busy"},  int'(bus.jump_busy),    (m_phase != 0) ? 1 : 0);
  endtask

  // One clock: drive inputs, advance the model over the edge, check #1 later.
  task automatic tick(input string tag, input logic [9:0] k, input logic f);
    bus.key_down = k;
    bus.freeze   = f;
    @(posedge clk);
    model_edge(k, f);
    #1;
    check_outputs(tag);
    if (bus.player_jump != 2'd0) air_cnt++;
  endtask

  localparam logic [9:0] K_NONE  = 10'b0;
  localparam logic [9:0] K_JUMP  = 10'b100;
  localparam logic [9:0] K_RIGHT = 10'b010;
  localparam logic [9:0] K_LEFT  = 10'b001;

  initial begin
    logic [9:0] k;
    logic       f;

    rst = 1'b0;
    bus.key_down = K_NONE;
    bus.freeze   = 1'b0;
    model_reset();
    #12;
    // Reset values, independent of the model
    check("reset.state", int'(bus.player_state), 6);
    check("reset.jump",  int'(bus.player_jump),  0);
    check("reset.busy",  int'(bus.jump_busy),    0);
    rst = 1'b1;
    #2;

    // 1: idle for 100 clocks
    for (int i = 0; i < 100; i++) tick("idle", K_NONE, 1'b0);

    // 2: single-clock jump pulse
    air_cnt = 0;
    tick("j1.start", K_JUMP, 1'b0);
    check("j1.first_state", int'(bus.player_state), 9);
    check("j1.first_jump",  int'(bus.player_jump),  1);
    for (int i = 0; i < 35; i++) tick("j1", K_NONE, 1'b0);
    check("j1.airtime", air_cnt, 2 * PHASE_LEN);
    check("j1.land_state", int'(bus.player_state), 6);

    // 3: right held, then jump; then left+right with jump
    tick("j2.right", K_RIGHT, 1'b0);
    air_cnt = 0;
    tick("j2.start", K_RIGHT | K_JUMP, 1'b0);
    check("j2.state_right", int'(bus.player_state), 7);
    for (int i = 0; i < 35; i++) tick("j2", K_RIGHT, 1'b0);
    check("j2.airtime", air_cnt, 2 * PHASE_LEN);
    tick("j3.lr", K_RIGHT | K_LEFT, 1'b0);
    check("j3.lr_static", int'(bus.player_state), 6);
    tick("j3.start", K_RIGHT | K_LEFT | K_JUMP, 1'b0);
    check("j3.lr_up", int'(bus.player_state), 9);
    for (int i = 0; i < 35; i++) tick("j3", K_RIGHT | K_LEFT, 1'b0);
    tick("j3.left", K_LEFT, 1'b0);
    check("j3.left", int'(bus.player_state), 8);

    // 4: re-press during rise, then hold jump through landing
    air_cnt = 0;
    tick("j4.start", K_JUMP, 1'b0);
    for (int i = 0; i < 4; i++) tick("j4.rise", K_NONE, 1'b0);
    tick("j4.repress", K_JUMP, 1'b0);
    for (int i = 0; i < 40; i++) tick("j4.held", K_JUMP, 1'b0);
    check("j4.airtime", air_cnt, 2 * PHASE_LEN);
    check("j4.no_retrigger", int'(bus.player_jump), 0);
    tick("j4.release", K_NONE, 1'b0);

    // 5: freeze 10 clocks at rise step 2
    air_cnt = 0;
    tick("j5.start", K_JUMP, 1'b0);
    for (int i = 0; i < 9; i++) tick("j5.rise", K_NONE, 1'b0);
    for (int i = 0; i < 10; i++) tick("j5.frz", K_NONE, 1'b1);
    check("j5.frz_state", int'(bus.player_state), 6);
    check("j5.frz_jump",  int'(bus.player_jump),  1);
    for (int i = 0; i < 25; i++) tick("j5.post", K_NONE, 1'b0);
    check("j5.airtime", air_cnt, 2 * PHASE_LEN + 10);

    // 6: asynchronous reset mid-fall
    tick("j6.start", K_JUMP, 1'b0);
    for (int i = 0; i < 20; i++) tick("j6.air", K_NONE, 1'b0);
    check("j6.pre_fall", int'(bus.player_jump), 2);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check("j6.rst_state", int'(bus.player_state), 6);
    check("j6.rst_jump",  int'(bus.player_jump),  0);
    check("j6.rst_busy",  int'(bus.jump_busy),    0);
    #13;
    rst = 1'b1;
    air_cnt = 0;
    tick("j6.restart", K_JUMP, 1'b0);
    for (int i = 0; i < 35; i++) tick("j6.post", K_NONE, 1'b0);
    check("j6.airtime", air_cnt, 2 * PHASE_LEN);

    // Randomized run: keys change slowly, occasional freezes
    k = K_NONE;
    f = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) k = 10'($urandom);
      if ($urandom_range(0, 15) == 0) f = ~f;
      tick("rand", k, f);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
